// File: rtl/gnt_rr_arbiter_if.sv
// Request/grant bundle between requesters and the round-robin grant arbiter.
// master = arbiter side (drives grants), slave = requester/consumer side.
interface gnt_rr_arbiter_if #(
    parameter int N = 4
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic          gnt_any;
    logic [IW-1:0] gnt_id;
    logic          timeout;
    logic [IW-1:0] timeout_id;
    logic [N-1:0]  mask;

    modport master (
        input  req,
        output gnt, gnt_any, gnt_id, timeout, timeout_id, mask
    );

    modport slave (
        output req,
        input  gnt, gnt_any, gnt_id, timeout, timeout_id, mask
    );
endinterface

// File: rtl/gnt_rr_arbiter.sv
// Round-robin grant arbiter with a tenure watchdog that forcibly revokes a grant
// held for MAX_HOLD cycles and masks the offender until it drops its request.
module gnt_rr_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               reset,
    gnt_rr_arbiter_if.master   bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(MAX_HOLD + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_GRANT  = 2'd1;
    localparam logic [1:0] S_REVOKE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  mask_q, mask_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [IW-1:0] gnt_id_q, gnt_id_d;
    logic          timeout_q, timeout_d;
    logic [IW-1:0] timeout_id_q, timeout_id_d;

    logic [N-1:0]  elig;
    logic          pick_vld;
    logic [IW-1:0] pick_idx;
    logic          owner_req;

    function automatic logic [N-1:0] onehot(input logic [IW-1:0] idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
        return (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c >= CW'(MAX_HOLD)) ? c : c + 1'b1;
    endfunction

    // Rotating priority search starting at the rr pointer.
    always_comb begin
        elig     = bus.req & ~mask_q;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (!pick_vld && elig[(int'(rr_ptr_q) + k) % N]) begin
                pick_vld = 1'b1;
                pick_idx = IW'((int'(rr_ptr_q) + k) % N);
            end
        end
    end

    assign owner_req = bus.req[owner_q];

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        cnt_d        = cnt_q;
        gnt_d        = '0;
        gnt_id_d     = '0;
        timeout_d    = 1'b0;
        timeout_id_d = '0;
        // A dropped request always lifts that requester's mask.
        mask_d       = mask_q & bus.req;

        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    state_d  = S_GRANT;
                    owner_d  = pick_idx;
                    cnt_d    = '0;
                    rr_ptr_d = next_idx(pick_idx);
                    gnt_d    = onehot(pick_idx);
                    gnt_id_d = pick_idx;
                end
            end
            S_GRANT: begin
                // Release wins over revoke when both land on the same edge.
                if (!owner_req) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CW'(MAX_HOLD - 1)) begin
                    state_d         = S_REVOKE;
                    mask_d[owner_q] = 1'b1;
                    timeout_d       = 1'b1;
                    timeout_id_d    = owner_q;
                end else begin
                    cnt_d    = sat_inc(cnt_q);
                    gnt_d    = onehot(owner_q);
                    gnt_id_d = owner_q;
                end
            end
            S_REVOKE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            cnt_q        <= '0;
            mask_q       <= '0;
            gnt_q        <= '0;
            gnt_id_q     <= '0;
            timeout_q    <= 1'b0;
            timeout_id_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            cnt_q        <= cnt_d;
            mask_q       <= mask_d;
            gnt_q        <= gnt_d;
            gnt_id_q     <= gnt_id_d;
            timeout_q    <= timeout_d;
            timeout_id_q <= timeout_id_d;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.gnt_any    = |gnt_q;
    assign bus.gnt_id     = gnt_id_q;
    assign bus.timeout    = timeout_q;
    assign bus.timeout_id = timeout_id_q;
    assign bus.mask       = mask_q;
endmodule

// File: tb/tb_gnt_rr_arbiter.sv
// Directed bench for gnt_rr_arbiter (N=4, MAX_HOLD=8).
module tb_gnt_rr_arbiter;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    gnt_rr_arbiter_if #(.N(4)) bus ();

    gnt_rr_arbiter #(.N(4), .MAX_HOLD(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        bus.req = 4'b0000;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        bus.req = 4'b0000;
        step();
        step();
        total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL rst_gnt got %b want 0000", bus.gnt); end
        total++; if (bus.gnt_any !== 1'b0) begin bad++; $display("FAIL rst_gnt_any got %b want 0", bus.gnt_any); end
        total++; if (bus.gnt_id !== 2'd0) begin bad++; $display("FAIL rst_gnt_id got %0d want 0", bus.gnt_id); end
        total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout got %b want 0", bus.timeout); end
        total++; if (bus.timeout_id !== 2'd0) begin bad++; $display("FAIL rst_timeout_id got %0d want 0", bus.timeout_id); end
        total++; if (bus.mask !== 4'b0000) begin bad++; $display("FAIL rst_mask got %b want 0000", bus.mask); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_single();
        bus.req = 4'b0100;
        total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL single_pre got %b want 0000", bus.gnt); end
        for (int c = 1; c <= 3; c++) begin
            step();
            total++; if (bus.gnt !== 4'b0100) begin bad++; $display("FAIL single_gnt c%0d got %b want 0100", c, bus.gnt); end
            total++; if (bus.gnt_id !== 2'd2) begin bad++; $display("FAIL single_id c%0d got %0d want 2", c, bus.gnt_id); end
            total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL single_to c%0d got %b want 0", c, bus.timeout); end
        end
        bus.req = 4'b0000;
        step();
        total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL single_rel got %b want 0000", bus.gnt); end
        total++; if (bus.gnt_id !== 2'd0) begin bad++; $display("FAIL single_rel_id got %0d want 0", bus.gnt_id); end
        total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL single_rel_to got %b want 0", bus.timeout); end
    endtask

    task automatic test_round_robin();
        logic [3:0] oh;
        do_reset();
        bus.req = 4'b1111;
        step();
        for (int i = 0; i < 5; i++) begin
            oh = 4'b0001 << (i % 4);
            total++; if (bus.gnt !== oh) begin bad++; $display("FAIL rr_gnt i%0d got %b want %b", i, bus.gnt, oh); end
            total++; if (bus.gnt_id !== 2'(i % 4)) begin bad++; $display("FAIL rr_id i%0d got %0d want %0d", i, bus.gnt_id, i % 4); end
            step();
            total++; if (bus.gnt !== oh) begin bad++; $display("FAIL rr_hold i%0d got %b want %b", i, bus.gnt, oh); end
            bus.req = 4'b1111 & ~oh;
            step();
            total++; if (bus.gnt_any !== 1'b0) begin bad++; $display("FAIL rr_gap i%0d got %b want 0", i, bus.gnt_any); end
            bus.req = 4'b1111;
            step();
        end
        bus.req = 4'b0000;
        step();
        step();
    endtask

    task automatic test_watchdog();
        bus.req = 4'b0010;
        step();
        for (int c = 1; c <= 8; c++) begin
            total++; if (bus.gnt !== 4'b0010) begin bad++; $display("FAIL wd_gnt c%0d got %b want 0010", c, bus.gnt); end
            total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL wd_early_to c%0d got %b want 0", c, bus.timeout); end
            step();
        end
        total++; if (bus.gnt_any !== 1'b0) begin bad++; $display("FAIL wd_revoke_gnt got %b want 0", bus.gnt_any); end
        total++; if (bus.timeout !== 1'b1) begin bad++; $display("FAIL wd_timeout got %b want 1", bus.timeout); end
        total++; if (bus.timeout_id !== 2'd1) begin bad++; $display("FAIL wd_timeout_id got %0d want 1", bus.timeout_id); end
        total++; if (bus.mask !== 4'b0010) begin bad++; $display("FAIL wd_mask got %b want 0010", bus.mask); end
        step();
        total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL wd_to_pulse got %b want 0", bus.timeout); end
        total++; if (bus.timeout_id !== 2'd0) begin bad++; $display("FAIL wd_to_id_clr got %0d want 0", bus.timeout_id); end
        for (int c = 0; c < 4; c++) begin
            total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL wd_masked c%0d got %b want 0000", c, bus.gnt); end
            step();
        end
        total++; if (bus.mask !== 4'b0010) begin bad++; $display("FAIL wd_mask_hold got %b want 0010", bus.mask); end
    endtask

    task automatic test_mask_release();
        bus.req = 4'b0000;
        step();
        total++; if (bus.mask !== 4'b0000) begin bad++; $display("FAIL mr_mask got %b want 0000", bus.mask); end
        total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL mr_idle got %b want 0000", bus.gnt); end
        bus.req = 4'b0010;
        step();
        total++; if (bus.gnt !== 4'b0010) begin bad++; $display("FAIL mr_regrant got %b want 0010", bus.gnt); end
        total++; if (bus.gnt_id !== 2'd1) begin bad++; $display("FAIL mr_regrant_id got %0d want 1", bus.gnt_id); end
        bus.req = 4'b0000;
        step();
        step();
    endtask

    task automatic test_coincident();
        bus.req = 4'b0001;
        step();
        for (int c = 1; c <= 7; c++) begin
            total++; if (bus.gnt !== 4'b0001) begin bad++; $display("FAIL co_gnt c%0d got %b want 0001", c, bus.gnt); end
            step();
        end
        total++; if (bus.gnt !== 4'b0001) begin bad++; $display("FAIL co_gnt8 got %b want 0001", bus.gnt); end
        bus.req = 4'b0000;
        step();
        total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL co_rel got %b want 0000", bus.gnt); end
        total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL co_timeout got %b want 0", bus.timeout); end
        total++; if (bus.mask !== 4'b0000) begin bad++; $display("FAIL co_mask got %b want 0000", bus.mask); end
        step();
        total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL co_timeout2 got %b want 0", bus.timeout); end
    endtask

    task automatic test_reset_mid_grant();
        bus.req = 4'b1000;
        for (int c = 1; c <= 4; c++) step();
        total++; if (bus.gnt !== 4'b1000) begin bad++; $display("FAIL rm_gnt got %b want 1000", bus.gnt); end
        #2 reset = 1'b1;
        #1;
        total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL rm_async_gnt got %b want 0000", bus.gnt); end
        total++; if (bus.gnt_any !== 1'b0) begin bad++; $display("FAIL rm_async_any got %b want 0", bus.gnt_any); end
        total++; if (bus.mask !== 4'b0000) begin bad++; $display("FAIL rm_async_mask got %b want 0000", bus.mask); end
        bus.req = 4'b1001;
        step();
        reset = 1'b0;
        step();
        total++; if (bus.gnt !== 4'b0001) begin bad++; $display("FAIL rm_first got %b want 0001", bus.gnt); end
        total++; if (bus.gnt_id !== 2'd0) begin bad++; $display("FAIL rm_first_id got %0d want 0", bus.gnt_id); end
        bus.req = 4'b0000;
        step();
        step();
    endtask

    task automatic test_reset_mid_revoke();
        bus.req = 4'b0010;
        step();
        for (int c = 1; c <= 8; c++) step();
        total++; if (bus.timeout !== 1'b1) begin bad++; $display("FAIL rv_timeout got %b want 1", bus.timeout); end
        total++; if (bus.mask !== 4'b0010) begin bad++; $display("FAIL rv_mask got %b want 0010", bus.mask); end
        #2 reset = 1'b1;
        #1;
        total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL rv_async_to got %b want 0", bus.timeout); end
        total++; if (bus.timeout_id !== 2'd0) begin bad++; $display("FAIL rv_async_to_id got %0d want 0", bus.timeout_id); end
        total++; if (bus.mask !== 4'b0000) begin bad++; $display("FAIL rv_async_mask got %b want 0000", bus.mask); end
        bus.req = 4'b0110;
        step();
        reset = 1'b0;
        step();
        total++; if (bus.gnt !== 4'b0010) begin bad++; $display("FAIL rv_first got %b want 0010", bus.gnt); end
        bus.req = 4'b0000;
        step();
        step();
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b1;
        bus.req = 4'b0000;
        test_reset();
        test_single();
        test_round_robin();
        test_watchdog();
        test_mask_release();
        test_coincident();
        test_reset_mid_grant();
        test_reset_mid_revoke();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gnt_rr_arbiter.md
# gnt_rr_arbiter

Round-robin grant arbiter that shares one resource among N requesters and drives the single-bit grant consumed by the downstream grant-tracking FSM. A grant is held for as long as its owner keeps requesting, up to MAX_HOLD cycles. A tenure watchdog then forcibly revokes the grant. This prevents the grant from staying ACTIVE indefinitely, which is the deadlock condition the tracker's assertion guards against.

## Interface
- N, 4, number of requesters (2..16)
- MAX_HOLD, 8, maximum consecutive cycles one grant may stay asserted (>= 2)

- clk  input  1  clock; all state updates on posedge
- reset  input  1  asynchronous, active-high
- req  input  N  per-requester request, level-sensitive
- gnt  output  N  one-hot (or zero) grant vector, registered
- gnt_any  output  1  OR of gnt; feeds the tracker's gnt input
- gnt_id  output  $clog2(N)  index of current owner; 0 when gnt_any=0
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked
- timeout_id  output  $clog2(N)  index of the revoked owner; valid only while timeout=1, else 0
- mask  output  N  requesters currently blocked after a revoke

## Operation
- States:
  - IDLE: no grant.
  - GRANT: one owner.
  - REVOKE: single-cycle forced release.
- Reset values: state=IDLE, gnt=0, gnt_any=0, gnt_id=0, timeout=0, timeout_id=0, mask=0, rr pointer=0, tenure count=0.
- Eligible set: req & ~mask.
- IDLE:
  - If the eligible set is non-zero, pick the first eligible index at or above the rr pointer, wrapping modulo N.
  - Load the owner, go to GRANT, and clear the tenure count to 0.
  - Set the rr pointer to (owner+1) mod N; wrap N-1 to 0.
- GRANT:
  - The count increments each cycle and saturates at MAX_HOLD; count width is $clog2(MAX_HOLD+1).
  - If req[owner]=0 at the edge: go to IDLE with gnt=0. This is a normal release, and mask is unchanged.
  - Else if count==MAX_HOLD-1 at the edge, meaning the grant has been high for MAX_HOLD cycles: go to REVOKE and set mask[owner].
  - Otherwise stay in GRANT.
- REVOKE:
  - gnt=0, timeout=1, timeout_id=owner.
  - Unconditionally go to IDLE next edge. No arbitration happens in REVOKE.
- mask[i] clears on any edge where req[i]=0. A clear and a set on the same bit in the same edge cannot occur, because a set requires req high.
- Only one grant ever exists. gnt is never asserted in IDLE or REVOKE.
- Release or revoke always passes through at least one IDLE cycle with gnt=0. This gives the tracker a visible IDLE before the next owner.
- A req change on a non-owner has no effect while in GRANT.

## Timing
- Grant latency:
  - If req rises before edge t with state IDLE and the requester eligible, gnt is high after edge t, i.e. 1 cycle.
  - Back-to-back owners: minimum gap is 1 cycle of gnt_any=0 after a normal release, and 2 cycles after a revoke (REVOKE then IDLE).
- Release latency: if req[owner] drops before edge t, gnt drops after edge t.
- Maximum tenure: gnt_any is high for exactly MAX_HOLD consecutive cycles on a revoke.
  - timeout is high in the first cycle with gnt_any=0.
- Boundary: if req[owner] drops at the same edge that would trigger the revoke, this is a normal release. timeout stays 0 and mask is not set.
- Reset mid-GRANT or mid-REVOKE:
  - All outputs go to their reset values immediately (asynchronous).
  - The first grant after deassertion uses rr pointer 0.
- A masked requester holding req high is never granted. It becomes eligible one edge after its req drops, and is then granted on a later req rise.

## Test plan
- Single requester: req[2]=1 for 3 cycles then 0 -> gnt=4'b0100 for 3 cycles, starting 1 cycle after req; gnt_id=2; timeout never asserted.
- Round robin: req=4'b1111, each owner drops req after 2 cycles of grant then re-raises -> owners granted in order 0,1,2,3,0; exactly 1 idle cycle between grants.
- Watchdog (MAX_HOLD=8): req[1] held high -> gnt[1] high exactly 8 cycles; next cycle timeout=1 with timeout_id=1; mask=4'b0010; req[1] is not re-granted while held high.
- Mask release: after the watchdog case, drop req[1] for 1 cycle then raise it -> mask clears; req[1] is granted again when it is the highest-priority eligible requester.
- Coincident release: req[0] drops at the edge ending the 8th grant cycle -> normal release; timeout=0; mask=0.
- Reset mid-grant: assert reset during cycle 4 of a grant to requester 3 -> gnt=0 and mask=0 immediately. After reset deasserts with req=4'b1001, requester 0 is granted first.
